// File: rtl/button_debounce.sv
// button_debounce
//   Synchronises one raw push-button, qualifies press and release over
//   STABLE_TICKS sample strobes, and generates auto-repeat events while the
//   button is held.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous, active-low reset
//   tick           1-cycle sample strobe (1 ms period in system)
//   btn_raw        raw, asynchronous, bouncing button (1 = pressed)
//   btn_level      debounced button state
//   press_pulse    1-cycle strobe: press accepted
//   release_pulse  1-cycle strobe: release accepted
//   repeat_pulse   1-cycle strobe: auto-repeat while held
module button_debounce #(
  parameter int unsigned STABLE_TICKS = 20,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100,
  parameter int unsigned CNT_W        = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_TICKS - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

  typedef enum logic [2:0] {
    REL   = 3'd0,
    P_CHK = 3'd1,
    HOLD  = 3'd2,
    RPT   = 3'd3,
    R_CHK = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;
  logic             rpt_f;   // repeat already started during this press
  logic             btn_s;

  assign btn_s = sync[1];

  // A disagreeing btn_s is tested before tick in every state, so an abort
  // always wins over a coincident strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync          <= '0;
      state         <= REL;
      cnt           <= '0;
      rpt_f         <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync          <= {sync[0], btn_raw};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;

      case (state)
        REL: begin
          if (btn_s) begin
            state <= P_CHK;
            cnt   <= '0;
          end
        end

        P_CHK: begin
          if (!btn_s) begin
            state <= REL;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state       <= HOLD;
              cnt         <= '0;
              rpt_f       <= 1'b0;
              press_pulse <= 1'b1;
              btn_level   <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          if (!btn_s) begin
            state <= R_CHK;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == HOLD_LAST) begin
              state        <= RPT;
              cnt          <= '0;
              rpt_f        <= 1'b1;
              repeat_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        RPT: begin
          if (!btn_s) begin
            state <= R_CHK;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == REPEAT_LAST) begin
              cnt          <= '0;
              repeat_pulse <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        R_CHK: begin
          if (btn_s) begin
            // Release rejected: resume where the press left off, timing restarts.
            state <= rpt_f ? RPT : HOLD;
            cnt   <= '0;
          end else if (tick) begin
            if (cnt == STABLE_LAST) begin
              state         <= REL;
              cnt           <= '0;
              release_pulse <= 1'b1;
              btn_level     <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state <= REL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce
//   Directed bench for button_debounce with STABLE=4, HOLD=10, REPEAT=3 and
//   a tick on every fifth clock edge (edges 5, 10, 15, ...). Expected pulse
//   positions are edge offsets from the moment btn_raw was changed.
module tb_button_debounce;

  logic clk;
  logic rst_n;
  logic tick;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic repeat_pulse;

  button_debounce #(
    .STABLE_TICKS (4),
    .HOLD_TICKS   (10),
    .REPEAT_TICKS (3),
    .CNT_W        (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick          (tick),
    .btn_raw       (btn_raw),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  int k       = 0;    // clock edges seen so far
  bit tick_en = 1'b1;

  int press_n, rel_n, rpt_n;
  int press_k, rel_k, rpt_first_k, rpt_last_k;
  int multi_n = 0;

  int base;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    press_n     = 0;
    rel_n       = 0;
    rpt_n       = 0;
    press_k     = -1;
    rel_k       = -1;
    rpt_first_k = -1;
    rpt_last_k  = -1;
  endtask

  // Advance n clock edges; tick is driven on the negedge before each edge,
  // outputs are sampled 1 time unit after the edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = tick_en && (((k + 1) % 5) == 0);
      @(posedge clk);
      k++;
      #1;
      if (press_pulse) begin
        press_n++;
        if (press_k < 0) press_k = k;
      end
      if (release_pulse) begin
        rel_n++;
        if (rel_k < 0) rel_k = k;
      end
      if (repeat_pulse) begin
        rpt_n++;
        if (rpt_first_k < 0) rpt_first_k = k;
        rpt_last_k = k;
      end
      if ((int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse)) > 1)
        multi_n++;
    end
  endtask

  task automatic align();
    while ((k % 5) != 0) cyc(1);
  endtask

  initial begin
    rst_n   = 1'b0;
    tick    = 1'b0;
    btn_raw = 1'b0;
    clear_mon();
    cyc(3);
    check("reset_level",   int'(btn_level),     0);
    check("reset_press",   int'(press_pulse),   0);
    check("reset_release", int'(release_pulse), 0);
    check("reset_repeat",  int'(repeat_pulse),  0);
    rst_n = 1'b1;
    align();

    // Clean press held for 120 clk: press at +20, repeats at +70/85/100/115.
    clear_mon();
    base    = k;
    btn_raw = 1'b1;
    cyc(120);
    check("hold_press_edge",   press_k - base, 20);
    check("hold_press_count",  press_n, 1);
    check("hold_level",        int'(btn_level), 1);
    check("hold_rpt_count",    rpt_n, 4);
    check("hold_rpt_first",    rpt_first_k - base, 70);
    check("hold_rpt_last",     rpt_last_k - base, 115);
    check("hold_no_release",   rel_n, 0);

    // Asynchronous reset while in RPT, button still held.
    clear_mon();
    rst_n = 1'b0;
    #1;
    check("rst_async_level",   int'(btn_level), 0);
    check("rst_async_press",   int'(press_pulse), 0);
    check("rst_async_release", int'(release_pulse), 0);
    check("rst_async_repeat",  int'(repeat_pulse), 0);
    cyc(3);
    rst_n = 1'b1;
    base  = k;
    cyc(30);
    check("rst_no_release",    rel_n, 0);
    check("rst_repress_edge",  press_k - base, 22);
    check("rst_repress_level", int'(btn_level), 1);
    align();

    // Release bounce in HOLD: 0 for two ticks only, then back to 1.
    clear_mon();
    btn_raw = 1'b0;
    cyc(10);
    btn_raw = 1'b1;
    cyc(5);
    check("rbounce_no_release", rel_n, 0);
    check("rbounce_level",      int'(btn_level), 1);

    // Genuine release: 0 held for well over four ticks.
    clear_mon();
    base    = k;
    btn_raw = 1'b0;
    cyc(30);
    check("release_count", rel_n, 1);
    check("release_edge",  rel_k - base, 20);
    check("release_level", int'(btn_level), 0);
    check("release_no_press",  press_n, 0);
    check("release_no_repeat", rpt_n, 0);

    // Press bounce: toggle every 7 clk for 56 clk, then rest at 0.
    clear_mon();
    for (int i = 0; i < 8; i++) begin
      btn_raw = (i % 2) == 0;
      cyc(7);
    end
    btn_raw = 1'b0;
    cyc(24);
    check("bounce_no_press", press_n, 0);
    check("bounce_level",    int'(btn_level), 0);
    align();

    // Abort priority: btn_s falls on the very tick that would reach cnt==3.
    clear_mon();
    btn_raw = 1'b1;
    cyc(17);
    btn_raw = 1'b0;
    cyc(20);
    check("abort_no_press", press_n, 0);
    check("abort_level",    int'(btn_level), 0);
    align();

    // Companion boundary: one more clk of high input is just enough.
    clear_mon();
    base    = k;
    btn_raw = 1'b1;
    cyc(18);
    btn_raw = 1'b0;
    cyc(27);
    check("edge_press_edge",   press_k - base, 20);
    check("edge_release_edge", rel_k - base, 40);
    align();

    // No strobes: nothing may ever qualify.
    clear_mon();
    tick_en = 1'b0;
    btn_raw = 1'b1;
    cyc(60);
    check("notick_no_press", press_n, 0);
    check("notick_level",    int'(btn_level), 0);
    btn_raw = 1'b0;
    cyc(5);
    tick_en = 1'b1;

    check("one_pulse_per_cycle", multi_n, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
